seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 41 ++++
 rtl/seg_scan_ctrl_prescaler.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 115 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants, types and helpers for the seven-segment digit scanner.
package seg_scan_pkg;

  localparam int unsigned DIGITS  = 8;
  localparam int unsigned DIGIT_W = 3;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } blink_phase_e;

  typedef struct packed {
    digit_t idx;
    logic   wrap;
  } next_t;

  function automatic digit_t bit_rev3(input digit_t d);
    return {d[0], d[1], d[2]};
  endfunction

  // Lowest enabled index strictly above cur, wrapping through 0 back to cur itself.
  function automatic next_t next_enabled(input digit_t cur, input logic [DIGITS-1:0] mask);
    next_t  r;
    logic   found;
    digit_t cand;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= DIGITS; i++) begin
      cand = cur + DIGIT_W'(i);
      if (!found && mask[cand]) begin
        found = 1'b1;
        r.idx = cand;
      end
    end
    r.wrap = found && (r.idx <= cur);
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_prescaler.sv
// Slot prescaler: counts 0..REFRESH_DIV-1 and flags the terminal count.
module scan_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic slot_o
);

  localparam int unsigned    CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign slot_o = (cnt_q == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan sequencer with masked digits and frame tick.
// Optional digit blinking is built when SCAN_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] en_mask,
  input  logic [7:0] blink_mask,
  output logic [2:0] sel,
  output logic [2:0] digit,
  output logic       blank,
  output logic       frame_tick
);

  logic   slot;
  digit_t ptr_q, ptr_d;
  digit_t digit_q, digit_d;
  digit_t sel_q;
  logic   en_blank_q, en_blank_d;
  logic   blank_q, blank_d;
  logic   tick_q, tick_d;
  next_t  nx;

  scan_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .slot_o(slot)
  );

  // Pointer starts at 7 so the first boundary lands on the lowest enabled digit.
  always_comb begin
    ptr_d      = ptr_q;
    digit_d    = digit_q;
    en_blank_d = en_blank_q;
    tick_d     = 1'b0;
    nx         = next_enabled(ptr_q, en_mask);
    if (slot) begin
      if (en_mask == '0) begin
        en_blank_d = 1'b1;
      end else begin
        ptr_d      = nx.idx;
        digit_d    = nx.idx;
        en_blank_d = 1'b0;
        tick_d     = nx.wrap;
      end
    end
  end

`ifdef SCAN_BLINK_EN
  localparam int unsigned   FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FLAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  blink_phase_e  phase_q, phase_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (tick_d) begin
      if (fcnt_q == FLAST) begin
        fcnt_d  = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q  <= '0;
      phase_q <= PH_ON;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank_d = en_blank_d | ((phase_d == PH_OFF) & blink_mask[digit_d]);
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask | (BLINK_FRAMES == 0);
  assign blank_d      = en_blank_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= DIGIT_W'(DIGITS - 1);
      digit_q    <= '0;
      sel_q      <= '0;
      en_blank_q <= 1'b1;
      blank_q    <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      digit_q    <= digit_d;
      sel_q      <= bit_rev3(digit_d);
      en_blank_q <= en_blank_d;
      blank_q    <= blank_d;
      tick_q     <= tick_d;
    end
  end

  assign sel        = sel_q;
  assign digit      = digit_q;
  assign blank      = blank_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (REFRESH_DIV=4, BLINK_FRAMES=2).
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] en_mask = 8'hFF;
  logic [7:0] blink_mask = 8'h00;
  logic [2:0] sel, digit;
  logic       blank, frame_tick;

  int checks = 0;
  int errors = 0;

  logic [2:0] sel_tab [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};

  seg_scan_ctrl #(
    .REFRESH_DIV (4),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en_mask   (en_mask),
    .blink_mask(blink_mask),
    .sel       (sel),
    .digit     (digit),
    .blank     (blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] m);
    reset   = 1'b1;
    en_mask = m;
    step();
    step();
    reset = 1'b0;
  endtask

  // Observed vector is {digit[2:0], sel[2:0], blank, frame_tick}.
  task automatic test_reset();
    logic [7:0] exp;
    reset   = 1'b1;
    en_mask = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {3'd0, 3'b000, 1'b1, 1'b0};
      checks++;
      if ({digit, sel, blank, frame_tick} !== exp) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", {digit, sel, blank, frame_tick}, exp);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4) ? {3'd0, 3'b000, 1'b0, 1'b1} : {3'd0, 3'b000, 1'b1, 1'b0};
      checks++;
      if ({digit, sel, blank, frame_tick} !== exp) begin
        errors++;
        $display("FAIL reset_first_slot step %0d: got %b expected %b", i, {digit, sel, blank, frame_tick}, exp);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [7:0] exp;
    do_reset(8'hFF);
    for (int i = 0; i < 3; i++) step();
    for (int s = 0; s < 9; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp = {3'(s % 8), sel_tab[s % 8], 1'b0, (c == 0) && (s % 8 == 0)};
        checks++;
        if ({digit, sel, blank, frame_tick} !== exp) begin
          errors++;
          $display("FAIL full_scan slot %0d clk %0d: got %b expected %b", s, c, {digit, sel, blank, frame_tick}, exp);
        end
      end
    end
  endtask

  task automatic test_two_digits();
    logic [7:0] exp;
    int seq [4] = '{1, 6, 1, 6};
    do_reset(8'b0100_0010);
    for (int i = 0; i < 3; i++) step();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp = {3'(seq[s]), sel_tab[seq[s]], 1'b0, (c == 0) && (seq[s] == 1)};
        checks++;
        if ({digit, sel, blank, frame_tick} !== exp) begin
          errors++;
          $display("FAIL two_digits slot %0d clk %0d: got %b expected %b", s, c, {digit, sel, blank, frame_tick}, exp);
        end
      end
    end
  endtask

  task automatic test_mask_change();
    logic [7:0] exp;
    int seq [8] = '{0, 1, 2, 3, 0, 0, 0, 0};
    do_reset(8'hFF);
    for (int i = 0; i < 3; i++) step();
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (s == 3 && c == 1) en_mask = 8'h01;
        exp = {3'(seq[s]), sel_tab[seq[s]], 1'b0, (c == 0) && (seq[s] == 0)};
        checks++;
        if ({digit, sel, blank, frame_tick} !== exp) begin
          errors++;
          $display("FAIL mask_change slot %0d clk %0d: got %b expected %b", s, c, {digit, sel, blank, frame_tick}, exp);
        end
      end
    end
  endtask

  task automatic test_mask_zero();
    logic [7:0] exp;
    do_reset(8'h00);
    for (int i = 1; i <= 24; i++) begin
      step();
      if (i == 12) en_mask = 8'h10;
      if (i == 17) en_mask = 8'h00;
      if (i == 20) en_mask = 8'h10;
      if (i <= 15)       exp = {3'd0, 3'b000, 1'b1, 1'b0};
      else if (i == 16)  exp = {3'd4, 3'b001, 1'b0, 1'b1};
      else if (i <= 19)  exp = {3'd4, 3'b001, 1'b0, 1'b0};
      else if (i <= 23)  exp = {3'd4, 3'b001, 1'b1, 1'b0};
      else               exp = {3'd4, 3'b001, 1'b0, 1'b1};
      checks++;
      if ({digit, sel, blank, frame_tick} !== exp) begin
        errors++;
        $display("FAIL mask_zero step %0d: got %b expected %b", i, {digit, sel, blank, frame_tick}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    do_reset(8'hFF);
    for (int i = 0; i < 25; i++) step();
    exp = {3'd5, 3'b101, 1'b0, 1'b0};
    checks++;
    if ({digit, sel, blank, frame_tick} !== exp) begin
      errors++;
      $display("FAIL reset_mid_pre: got %b expected %b", {digit, sel, blank, frame_tick}, exp);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp = {3'd0, 3'b000, 1'b1, 1'b0};
    checks++;
    if ({digit, sel, blank, frame_tick} !== exp) begin
      errors++;
      $display("FAIL reset_mid_clear: got %b expected %b", {digit, sel, blank, frame_tick}, exp);
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i <= 3)      exp = {3'd0, 3'b000, 1'b1, 1'b0};
      else if (i == 4) exp = {3'd0, 3'b000, 1'b0, 1'b1};
      else if (i <= 7) exp = {3'd0, 3'b000, 1'b0, 1'b0};
      else             exp = {3'd1, 3'b100, 1'b0, 1'b0};
      checks++;
      if ({digit, sel, blank, frame_tick} !== exp) begin
        errors++;
        $display("FAIL reset_mid_restart step %0d: got %b expected %b", i, {digit, sel, blank, frame_tick}, exp);
      end
    end
  endtask

`ifdef SCAN_BLINK_EN
  task automatic test_blink();
    logic [7:0] exp;
    logic       bl;
    blink_mask = 8'h01;
    do_reset(8'hFF);
    for (int i = 0; i < 3; i++) step();
    for (int f = 1; f <= 7; f++) begin
      for (int d = 0; d < 8; d++) begin
        for (int c = 0; c < 4; c++) begin
          step();
          bl  = (d == 0) && (((f / 2) % 2) == 1);
          exp = {3'(d), sel_tab[d], bl, (c == 0) && (d == 0)};
          checks++;
          if ({digit, sel, blank, frame_tick} !== exp) begin
            errors++;
            $display("FAIL blink frame %0d digit %0d clk %0d: got %b expected %b", f, d, c, {digit, sel, blank, frame_tick}, exp);
          end
        end
      end
    end
    blink_mask = 8'h00;
  endtask
`else
  task automatic test_blink();
    logic [7:0] exp;
    blink_mask = 8'hFF;
    do_reset(8'hFF);
    for (int i = 0; i < 3; i++) step();
    for (int s = 0; s < 32; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        exp = {3'(s % 8), sel_tab[s % 8], 1'b0, (c == 0) && (s % 8 == 0)};
        checks++;
        if ({digit, sel, blank, frame_tick} !== exp) begin
          errors++;
          $display("FAIL blink_ignored slot %0d clk %0d: got %b expected %b", s, c, {digit, sel, blank, frame_tick}, exp);
        end
      end
    end
    blink_mask = 8'h00;
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_two_digits();
    test_mask_change();
    test_mask_zero();
    test_reset_mid();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
